// File: rtl/blitter_if.sv
// Bus bundle for the blitter: CPU store snoop, hold/ack handshake and shared memory port.
interface blitter_if;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_memwt;
    logic          hold;
    logic          hold_ack;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    modport master (
        input  cpu_addr, cpu_data, cpu_memwt, hold_ack, mem_rdata,
        output hold, mem_sel, mem_addr, mem_wdata, mem_we, busy, done
    );

    modport slave (
        output cpu_addr, cpu_data, cpu_memwt, hold_ack, mem_rdata,
        input  hold, mem_sel, mem_addr, mem_wdata, mem_we, busy, done
    );
endinterface

// File: rtl/blitter.sv
// Memory-to-memory copy/fill engine; programmed by snooping CPU stores into a 5-word window.
module blitter #(
    parameter logic [11:0] REG_BASE = 12'hFF8
) (
    input  logic      clk,
    input  logic      rst,
    blitter_if.master bus
);
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, REL} state_t;

    state_t        state, state_n;
    logic [AW-1:0] src_q, dst_q, len_q;
    logic [DW-1:0] fill_q;
    logic [AW-1:0] src_ptr, src_ptr_n, dst_ptr, dst_ptr_n, count, count_n;
    logic [DW-1:0] data_q, data_n;
    logic          mode_q, mode_n;
    logic          hold_q, hold_n, sel_q, sel_n, we_q, we_n;
    logic          busy_q, busy_n, done_q, done_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic [AW-1:0] reg_off;
    logic          reg_wr, start;

    // Register window decode; ignored unless the engine is idle
    always_comb begin
        reg_off = AW'(bus.cpu_addr - REG_BASE);
        reg_wr  = bus.cpu_memwt && (reg_off < AW'(5)) && (state == IDLE);
        start   = reg_wr && (reg_off == AW'(4)) && bus.cpu_data[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
        end else if (reg_wr) begin
            case (reg_off[2:0])
                3'd0:    src_q  <= bus.cpu_data[AW-1:0];
                3'd1:    dst_q  <= bus.cpu_data[AW-1:0];
                3'd2:    len_q  <= bus.cpu_data[AW-1:0];
                3'd3:    fill_q <= bus.cpu_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
            hold_q  <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            src_ptr <= src_ptr_n;
            dst_ptr <= dst_ptr_n;
            count   <= count_n;
            data_q  <= data_n;
            mode_q  <= mode_n;
            hold_q  <= hold_n;
            sel_q   <= sel_n;
            we_q    <= we_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    // Next state plus bus outputs computed from the next state, so they register in step with it
    always_comb begin
        state_n   = state;
        src_ptr_n = src_ptr;
        dst_ptr_n = dst_ptr;
        count_n   = count;
        data_n    = data_q;
        mode_n    = mode_q;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    src_ptr_n = src_q;
                    dst_ptr_n = dst_q;
                    count_n   = len_q;
                    mode_n    = bus.cpu_data[1];
                    if (len_q != '0) state_n = REQ;
                    else             done_n  = 1'b1;
                end
            end
            REQ: begin
                if (bus.hold_ack) state_n = mode_q ? WRITE : READ;
            end
            READ: begin
                data_n    = bus.mem_rdata;
                src_ptr_n = AW'(src_ptr + AW'(1));
                state_n   = WRITE;
            end
            WRITE: begin
                dst_ptr_n = AW'(dst_ptr + AW'(1));
                count_n   = AW'(count - AW'(1));
                if (count == AW'(1)) state_n = REL;
                else                 state_n = mode_q ? WRITE : READ;
            end
            REL: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        hold_n  = (state_n == REQ) || (state_n == READ) || (state_n == WRITE);
        sel_n   = (state_n == READ) || (state_n == WRITE);
        we_n    = (state_n == WRITE);
        busy_n  = (state_n != IDLE);
        done_n  = done_n || (state_n == REL);
        addr_n  = (state_n == READ) ? src_ptr_n : dst_ptr_n;
        wdata_n = mode_n ? fill_q : data_n;
    end

    assign bus.hold      = hold_q;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_we    = we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_blitter.sv
// Directed bench for blitter: memory + CPU grant model, write scoreboard, timing checks.
module tb_blitter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blitter_if bus();
    blitter dut (.clk(clk), .rst(rst), .bus(bus.master));

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] mem [4096];
    wr_t         sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          writes_seen = 0;
    int          ack_delay = 0;
    int          ack_cnt = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Memory commit and CPU grant: ack follows hold after ack_delay+1 edges, drops right after hold
    always @(posedge clk) begin
        if (bus.mem_sel && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (!bus.hold) begin
            bus.hold_ack <= 1'b0;
            ack_cnt      <= 0;
        end else if (ack_cnt >= ack_delay) begin
            bus.hold_ack <= 1'b1;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Scoreboard: every DMA write must match the next expected (addr, data)
    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            wr_t e;
            writes_seen++;
            check("we_without_sel", 32'(bus.mem_sel), 32'd1);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_addr", 32'(bus.mem_addr), 32'(e.a));
                check("sb_data", 32'(bus.mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic cpu_wr(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.cpu_addr  = a;
        bus.cpu_data  = d;
        bus.cpu_memwt = 1'b1;
        @(negedge clk);
        bus.cpu_memwt = 1'b0;
        bus.cpu_addr  = 12'h000;
    endtask

    task automatic push(input logic [11:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    // Cycle 1 is the CTRL write cycle; returns the cycle index in which done is seen
    task automatic run(input logic [15:0] ctrl, output int done_at, output int hold_cyc,
                       output int done_cnt, output int we_cyc, output int sel_pre_ack);
        int idx;
        bit ack_seen;
        done_at = 0; hold_cyc = 0; done_cnt = 0; we_cyc = 0; sel_pre_ack = 0;
        ack_seen = 1'b0;
        cpu_wr(12'hFFC, ctrl);
        idx = 2;
        for (int n = 0; n < 200; n++) begin
            if (bus.hold) hold_cyc++;
            if (bus.mem_we) we_cyc++;
            if (bus.mem_sel && !ack_seen) sel_pre_ack++;
            if (bus.hold_ack) ack_seen = 1'b1;
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = idx;
            end
            if (done_at != 0 && idx >= done_at + 2) break;
            @(negedge clk);
            idx++;
        end
        check("run_timeout", 32'(done_at != 0), 32'd1);
    endtask

    initial begin
        int d_at, h_cyc, d_cnt, w_cyc, s_pre, base;
        rst           = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_data  = '0;
        bus.cpu_memwt = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] <= 16'hA100 + 16'(i * 16'h0111);
        repeat (3) @(negedge clk);
        check("rst_hold", 32'(bus.hold), 32'd0);
        check("rst_sel", 32'(bus.mem_sel), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // Copy 4 words 0x100 -> 0x200
        cpu_wr(12'hFF8, 16'h0100);
        cpu_wr(12'hFF9, 16'h0200);
        cpu_wr(12'hFFA, 16'h0004);
        for (int i = 0; i < 4; i++) push(12'h200 + 12'(i), 16'hA100 + 16'(i * 16'h0111));
        run(16'h0001, d_at, h_cyc, d_cnt, w_cyc, s_pre);
        check("copy_done_at", 32'(d_at), 32'd12);
        check("copy_hold_cyc", 32'(h_cyc), 32'd10);
        check("copy_done_cnt", 32'(d_cnt), 32'd1);
        check("copy_we_cyc", 32'(w_cyc), 32'd4);
        check("copy_sb_empty", 32'(sb.size()), 32'd0);
        check("copy_dst3", 32'(mem[12'h203]), 32'h0000A433);
        check("copy_src0", 32'(mem[12'h100]), 32'h0000A100);
        check("copy_src3", 32'(mem[12'h103]), 32'h0000A433);

        // Fill 3 words at 0x300
        cpu_wr(12'hFF9, 16'h0300);
        cpu_wr(12'hFFA, 16'h0003);
        cpu_wr(12'hFFB, 16'hBEEF);
        for (int i = 0; i < 3; i++) push(12'h300 + 12'(i), 16'hBEEF);
        run(16'h0003, d_at, h_cyc, d_cnt, w_cyc, s_pre);
        check("fill_done_at", 32'(d_at), 32'd7);
        check("fill_we_cyc", 32'(w_cyc), 32'd3);
        check("fill_hold_cyc", 32'(h_cyc), 32'd5);
        check("fill_sb_empty", 32'(sb.size()), 32'd0);
        check("fill_302", 32'(mem[12'h302]), 32'h0000BEEF);
        check("fill_303_untouched", 32'(mem[12'h303]), 32'h00000000);

        // LEN=0: immediate done, no bus activity
        cpu_wr(12'hFFA, 16'h0000);
        run(16'h0001, d_at, h_cyc, d_cnt, w_cyc, s_pre);
        check("len0_done_at", 32'(d_at), 32'd2);
        check("len0_hold_cyc", 32'(h_cyc), 32'd0);
        check("len0_we_cyc", 32'(w_cyc), 32'd0);
        check("len0_done_cnt", 32'(d_cnt), 32'd1);

        // Fill across the top of memory
        cpu_wr(12'hFF9, 16'h0FFE);
        cpu_wr(12'hFFA, 16'h0004);
        cpu_wr(12'hFFB, 16'h1234);
        push(12'hFFE, 16'h1234); push(12'hFFF, 16'h1234);
        push(12'h000, 16'h1234); push(12'h001, 16'h1234);
        run(16'h0003, d_at, h_cyc, d_cnt, w_cyc, s_pre);
        check("wrap_done_at", 32'(d_at), 32'd8);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        check("wrap_mem000", 32'(mem[12'h000]), 32'h00001234);

        // Grant delayed by 10 cycles
        ack_delay = 10;
        cpu_wr(12'hFF9, 16'h0240);
        for (int i = 0; i < 4; i++) push(12'h240 + 12'(i), 16'hA100 + 16'(i * 16'h0111));
        run(16'h0001, d_at, h_cyc, d_cnt, w_cyc, s_pre);
        check("dly_sel_before_ack", 32'(s_pre), 32'd0);
        check("dly_done_at", 32'(d_at), 32'd22);
        check("dly_sb_empty", 32'(sb.size()), 32'd0);
        check("dly_dst3", 32'(mem[12'h243]), 32'h0000A433);
        ack_delay = 0;

        // Reset right after the 2nd write of an 8-word copy
        cpu_wr(12'hFF9, 16'h0400);
        cpu_wr(12'hFFA, 16'h0008);
        for (int i = 0; i < 8; i++) push(12'h400 + 12'(i), 16'hA100 + 16'(i * 16'h0111));
        base = writes_seen;
        cpu_wr(12'hFFC, 16'h0001);
        for (int n = 0; n < 100 && writes_seen < base + 2; n++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_hold", 32'(bus.hold), 32'd0);
        check("abort_sel", 32'(bus.mem_sel), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_writes", 32'(writes_seen - base), 32'd2);
        check("abort_401", 32'(mem[12'h401]), 32'h0000A211);
        check("abort_402", 32'(mem[12'h402]), 32'h00000000);
        sb.delete();
        rst = 1'b0;

        // Registers were cleared by reset; reprogram and run normally
        cpu_wr(12'hFF8, 16'h0100);
        cpu_wr(12'hFF9, 16'h0500);
        cpu_wr(12'hFFA, 16'h0002);
        push(12'h500, 16'hA100); push(12'h501, 16'hA211);
        run(16'h0001, d_at, h_cyc, d_cnt, w_cyc, s_pre);
        check("post_done_at", 32'(d_at), 32'd8);
        check("post_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
